alu_host_sequencer: RTL and testbench

- Host-side initiator for the 4-bit ALU command interface. It accepts operation commands over a valid/ready port and drives the ALU's operands, op_select and start pulse.
- It waits for the ALU's result_valid response, then captures the result and flags into a small response FIFO.
- It sits between a test/host controller and the ALU control/datapath pair and serialises commands one at a time.
- A watchdog guarantees that every accepted command yields exactly one response.

---
 rtl/alu_host_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_host_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_host_sequencer.sv
// alu_host_sequencer: host-side initiator for the 4-bit ALU command port.
// Takes one command at a time, pulses alu_start, waits for a rising
// alu_result_valid (or a watchdog expiry) and queues exactly one response
// per accepted command in a small FIFO.
module alu_host_sequencer #(
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [3:0]                 cmd_a,
  input  logic [3:0]                 cmd_b,
  output logic                       alu_start,
  output logic [2:0]                 alu_op_select,
  output logic [3:0]                 alu_operand_a,
  output logic [3:0]                 alu_operand_b,
  input  logic                       alu_busy,
  input  logic                       alu_result_valid,
  input  logic [7:0]                 alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_carry,
  input  logic                       alu_overflow,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_data,
  output logic [3:0]                 rsp_flags,
  output logic [$clog2(RSP_DEPTH):0] rsp_level,
  output logic                       idle
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW:0]   DEPTH_L = (PW+1)'(RSP_DEPTH);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  typedef struct packed {
    logic [3:0] flags;   // {timeout, overflow, carry, zero}
    logic [7:0] data;
  } rsp_t;

  state_e          state_q;
  logic            start_q;
  logic [2:0]      op_q;
  logic [3:0]      a_q, b_q;
  logic [CW-1:0]   cnt_q;
  logic            prev_rv_q;

  rsp_t            mem_q [RSP_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     level_q, level_d;

  logic            accept, capture, timeout, push, pop;
  rsp_t            push_entry;

  // Busy is status only; capture is qualified purely by the result_valid edge.
  logic            busy_unused;
  assign busy_unused = alu_busy;

  // Handshake, capture/timeout decode and the entry to be queued.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE) && (level_q < DEPTH_L);
    accept     = cmd_valid && cmd_ready;
    capture    = (state_q == S_WAIT) && alu_result_valid && !prev_rv_q;
    timeout    = (state_q == S_WAIT) && !capture && (cnt_q == CNT_LIM);
    push       = capture || timeout;
    pop        = (level_q != '0) && rsp_ready;
    push_entry = '{flags: 4'b1000, data: 8'h00};
    if (capture) push_entry = '{flags: {1'b0, alu_overflow, alu_carry, alu_zero},
                                data:  alu_result};
  end

  // Command FSM with registered ALU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      prev_rv_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            a_q       <= cmd_a;
            b_q       <= cmd_b;
            start_q   <= 1'b1;
            prev_rv_q <= 1'b0;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Sampling result_valid here makes a level left over from the
          // previous operation look "old" on the first WAIT cycle.
          cnt_q     <= '0;
          prev_rv_q <= alu_result_valid;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          prev_rv_q <= alu_result_valid;
          if (push) state_q <= S_IDLE;
          else      cnt_q   <= cnt_q + CW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Next FIFO occupancy; push+pop together leaves it unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (PW+1)'(1);
      2'b01:   level_d = level_q - (PW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at RSP_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // FIFO storage; contents are only meaningful behind a valid level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign alu_start     = start_q;
  assign alu_op_select = op_q;
  assign alu_operand_a = a_q;
  assign alu_operand_b = b_q;
  assign rsp_valid     = (level_q != '0);
  assign rsp_data      = mem_q[rd_ptr_q].data;
  assign rsp_flags     = mem_q[rd_ptr_q].flags;
  assign rsp_level     = level_q;
  assign idle          = (state_q == S_IDLE) && (level_q == '0);

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Directed bench for alu_host_sequencer: the bench plays the ALU by hand,
// driving inputs on the falling edge and sampling outputs there as well.
module tb_alu_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic       alu_start;
  logic [2:0] alu_op_select;
  logic [3:0] alu_operand_a, alu_operand_b;
  logic       alu_busy = 1'b0, alu_result_valid = 1'b0;
  logic [7:0] alu_result = '0;
  logic       alu_zero = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [2:0] rsp_level;
  logic       idle;

  int n_pass = 0;
  int n_total = 0;

  alu_host_sequencer #(.RSP_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op_select(alu_op_select),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_busy(alu_busy), .alu_result_valid(alu_result_valid), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_level(rsp_level), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // Play one command: accept, hold result_valid low for dly WAIT cycles, then
  // raise it for the capture cycle. Returns on the falling edge after capture.
  task automatic issue_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] res, input logic z, input logic c, input logic o,
                          input int dly, input bit hold_rv, input bit pop_cap, output bit ok);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    ok = (cmd_ready === 1'b1);
    if (ok) begin
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (dly + 1) @(negedge clk);
      alu_result_valid = 1'b1; alu_result = res;
      alu_zero = z; alu_carry = c; alu_overflow = o;
      if (pop_cap) rsp_ready = 1'b1;
      @(negedge clk);
      if (!hold_rv) alu_result_valid = 1'b0;
      alu_zero = 1'b0; alu_carry = 1'b0; alu_overflow = 1'b0;
      if (pop_cap) rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({alu_start, rsp_valid, rsp_level, alu_operand_a, alu_operand_b, alu_op_select} !== '0)
      $display("FAIL reset_outputs: got start=%b rv=%b lvl=%0d a=%h b=%h op=%h expected all 0",
               alu_start, rsp_valid, rsp_level, alu_operand_a, alu_operand_b, alu_op_select);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({idle, cmd_ready, alu_start, rsp_valid} !== 4'b1100)
      $display("FAIL reset_release: got idle=%b ready=%b start=%b rv=%b expected 1 1 0 0",
               idle, cmd_ready, alu_start, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd3; cmd_b = 4'd4;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL single_ready: got %b expected 1", cmd_ready);
    else n_pass++;
    @(negedge clk);                       // ISSUE
    cmd_valid = 1'b0;
    n_total++;
    if ({alu_start, alu_op_select, alu_operand_a, alu_operand_b} !== {1'b1, 3'd0, 4'd3, 4'd4})
      $display("FAIL single_issue: got start=%b op=%h a=%h b=%h expected 1 0 3 4",
               alu_start, alu_op_select, alu_operand_a, alu_operand_b);
    else n_pass++;
    @(negedge clk);                       // WAIT 1
    n_total++;
    if ({alu_start, cmd_ready, rsp_valid} !== 3'b000)
      $display("FAIL single_start_pulse: got start=%b ready=%b rv=%b expected 0 0 0",
               alu_start, cmd_ready, rsp_valid);
    else n_pass++;
    @(negedge clk);                       // WAIT 2
    @(negedge clk);                       // WAIT 3: ALU result arrives
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_early_rsp: got %b expected 0", rsp_valid);
    else n_pass++;
    alu_result_valid = 1'b1; alu_result = 8'h07;
    @(negedge clk);                       // 5 cycles after acceptance
    alu_result_valid = 1'b0;
    n_total++;
    if ({rsp_valid, rsp_data, rsp_flags, rsp_level} !== {1'b1, 8'h07, 4'h0, 3'd1})
      $display("FAIL single_rsp: got rv=%b data=%h flags=%b lvl=%0d expected 1 07 0000 1",
               rsp_valid, rsp_data, rsp_flags, rsp_level);
    else n_pass++;
    n_total++;
    if ({alu_operand_a, alu_operand_b} !== {4'd3, 4'd4})
      $display("FAIL single_hold: got a=%h b=%h expected 3 4", alu_operand_a, alu_operand_b);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if ({rsp_valid, idle} !== 2'b01)
      $display("FAIL single_pop: got rv=%b idle=%b expected 0 1", rsp_valid, idle);
    else n_pass++;
  endtask

  task automatic test_flags_stale();
    bit ok;
    issue_op(3'd1, 4'h8, 4'h8, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, ok);
    n_total++;
    if (!ok || {rsp_data, rsp_flags} !== {8'h00, 4'b0011})
      $display("FAIL flags_zc: got ok=%b data=%h flags=%b expected 1 00 0011", ok, rsp_data, rsp_flags);
    else n_pass++;
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    // result_valid is still high from the previous operation
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_a = 4'h1; cmd_b = 4'h2;
    @(negedge clk);                       // ISSUE
    cmd_valid = 1'b0; alu_result = 8'hAA;
    @(negedge clk);                       // WAIT 1, stale high
    @(negedge clk);                       // WAIT 2, stale high
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL stale_ignored: got rv=%b expected 0", rsp_valid);
    else n_pass++;
    alu_result_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL stale_low: got rv=%b expected 0", rsp_valid);
    else n_pass++;
    alu_result_valid = 1'b1; alu_result = 8'h33;
    @(negedge clk);
    alu_result_valid = 1'b0;
    n_total++;
    if ({rsp_valid, rsp_data, rsp_flags, rsp_level} !== {1'b1, 8'h33, 4'h0, 3'd1})
      $display("FAIL stale_fresh_edge: got rv=%b data=%h flags=%b lvl=%0d expected 1 33 0000 1",
               rsp_valid, rsp_data, rsp_flags, rsp_level);
    else n_pass++;
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 4'h5; cmd_b = 4'h6;
    @(negedge clk);                       // ISSUE
    cmd_valid = 1'b0;
    repeat (16) @(negedge clk);           // 16th WAIT cycle
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL timeout_early: got rv=%b expected 0", rsp_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({rsp_valid, rsp_data, rsp_flags, cmd_ready} !== {1'b1, 8'h00, 4'b1000, 1'b1})
      $display("FAIL timeout_rsp: got rv=%b data=%h flags=%b ready=%b expected 1 00 1000 1",
               rsp_valid, rsp_data, rsp_flags, cmd_ready);
    else n_pass++;
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    // capture edge lands on the limit cycle
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (16) @(negedge clk);
    alu_result_valid = 1'b1; alu_result = 8'h5A; alu_overflow = 1'b1;
    @(negedge clk);
    alu_result_valid = 1'b0; alu_overflow = 1'b0;
    n_total++;
    if ({rsp_data, rsp_flags, rsp_level} !== {8'h5A, 4'b0100, 3'd1})
      $display("FAIL timeout_capture_wins: got data=%h flags=%b lvl=%0d expected 5a 0100 1",
               rsp_data, rsp_flags, rsp_level);
    else n_pass++;
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [7:0] exp_q [4];
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_op(3'(i), 4'(i), 4'(i + 1), 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, i, 1'b0, 1'b0, ok);
      n_total++;
      if (!ok) $display("FAIL bp_issue%0d: got ready=0 expected ready=1", i);
      else n_pass++;
    end
    n_total++;
    if ({rsp_level, cmd_ready} !== {3'd4, 1'b0})
      $display("FAIL bp_full: got lvl=%0d ready=%b expected 4 0", rsp_level, cmd_ready);
    else n_pass++;
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_a = 4'h5; cmd_b = 4'h5;
    @(negedge clk);
    n_total++;
    if ({cmd_ready, alu_start, rsp_level} !== {1'b0, 1'b0, 3'd4})
      $display("FAIL bp_held: got ready=%b start=%b lvl=%0d expected 0 0 4",
               cmd_ready, alu_start, rsp_level);
    else n_pass++;
    n_total++;
    if (rsp_data !== 8'h11) $display("FAIL bp_head: got %h expected 11", rsp_data);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if ({cmd_ready, rsp_level} !== {1'b1, 3'd3})
      $display("FAIL bp_reopen: got ready=%b lvl=%0d expected 1 3", cmd_ready, rsp_level);
    else n_pass++;
    issue_op(3'd5, 4'h5, 4'h5, 8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, ok);
    n_total++;
    if (!ok || rsp_level !== 3'd4)
      $display("FAIL bp_fifth: got ok=%b lvl=%0d expected 1 4", ok, rsp_level);
    else n_pass++;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (rsp_data !== exp_q[i]) $display("FAIL bp_order%0d: got %h expected %h", i, rsp_data, exp_q[i]);
      else n_pass++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    n_total++;
    if ({rsp_level, idle} !== {3'd0, 1'b1})
      $display("FAIL bp_drained: got lvl=%0d idle=%b expected 0 1", rsp_level, idle);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    bit ok0, ok1, ok2;
    issue_op(3'd1, 4'h1, 4'h1, 8'h61, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, ok0);
    issue_op(3'd1, 4'h2, 4'h2, 8'h62, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, ok1);
    n_total++;
    if (!(ok0 && ok1) || rsp_level !== 3'd2)
      $display("FAIL pp_setup: got ok=%b%b lvl=%0d expected 11 2", ok0, ok1, rsp_level);
    else n_pass++;
    issue_op(3'd1, 4'h3, 4'h3, 8'h63, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, ok2);
    n_total++;
    if (!ok2 || {rsp_level, rsp_data} !== {3'd2, 8'h62})
      $display("FAIL pp_same_cycle: got ok=%b lvl=%0d head=%h expected 1 2 62", ok2, rsp_level, rsp_data);
    else n_pass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (rsp_data !== 8'h63) $display("FAIL pp_wrap_order: got %h expected 63", rsp_data);
    else n_pass++;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_total++;
    if ({rsp_level, rsp_valid} !== {3'd0, 1'b0})
      $display("FAIL pp_empty: got lvl=%0d rv=%b expected 0 0", rsp_level, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 4'h9; cmd_b = 4'hA;
    @(negedge clk);                       // ISSUE
    cmd_valid = 1'b0;
    n_total++;
    if (alu_start !== 1'b1) $display("FAIL rst_pre_start: got %b expected 1", alu_start);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({alu_start, alu_operand_a} !== {1'b0, 4'h0})
      $display("FAIL rst_async_start: got start=%b a=%h expected 0 0", alu_start, alu_operand_a);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // reset while waiting, with a result edge arriving in that cycle
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);                       // WAIT 1
    alu_result_valid = 1'b1; alu_result = 8'h77;
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; alu_result_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({rsp_valid, rsp_level, idle, alu_start} !== {1'b0, 3'd0, 1'b1, 1'b0})
      $display("FAIL rst_wait_abandon: got rv=%b lvl=%0d idle=%b start=%b expected 0 0 1 0",
               rsp_valid, rsp_level, idle, alu_start);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags_stale();
    test_timeout();
    test_back_pressure();
    test_push_pop();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
